// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the sync_fifo_flex family.
// Sizing functions and parameter legality checks used at elaboration.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // One extra MSB beyond the address lets full and empty be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_ok(input int depth, input int afull_thr);
    return (afull_thr >= 1) && (afull_thr <= depth);
  endfunction

  function automatic bit aempty_ok(input int depth, input int aempty_thr);
    return (aempty_thr >= 0) && (aempty_thr <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for sync_fifo_flex: one synchronous write port, one asynchronous read port.
// Contents are intentionally never reset.
module fifo_mem_2p #(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags, overflow/underflow
// pulses, synchronous flush and a selectable registered or first-word-fall-through read.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DWIDTH     = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     rd_en,
  output logic [DWIDTH-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THR);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THR);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of 2 and >= 2");
  end
  if (!afull_ok(DEPTH, AFULL_THR)) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THR must lie in 1..DEPTH");
  end
  if (!aempty_ok(DEPTH, AEMPTY_THR)) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THR must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DWIDTH-1:0] rd_data;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign almost_full  = (count_q >= AFULL_C);

  // Acceptance looks only at this cycle's flags, never at the opposite port's activity.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    dout_d      = dout_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      dout_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (rd_acc) begin
        rptr_d = rptr_q + PW'(1);
        if (MODE == FIFO_STD) begin
          dout_d = rd_data;
        end
      end
      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;
    end
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .we     (wr_acc & ~flush & rstn),
    .waddr  (wptr_q[AW-1:0]),
    .wdata  (din),
    .raddr  (rptr_q[AW-1:0]),
    .rdata  (rd_data)
  );

  // In FWFT mode the head word is shown directly; the dout register then stays at zero.
  assign dout      = (MODE == FIFO_FWFT) ? (empty ? '0 : rd_data) : dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: a registered-read and an FWFT instance share
// stimulus and are both compared every cycle against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int DEPTH  = 8;
  localparam int DWIDTH = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              wr_en;
  logic              rd_en;
  logic [DWIDTH-1:0] din;

  logic [DWIDTH-1:0] s_dout, f_dout;
  logic              s_empty, s_full, s_aempty, s_afull, s_ovf, s_unf;
  logic              f_empty, f_full, f_aempty, f_afull, f_ovf, f_unf;
  logic [CW-1:0]     s_count, f_count;

  int errors = 0;
  int checks = 0;

  logic [DWIDTH-1:0] exp_q [$];
  logic [DWIDTH-1:0] exp_dout_std = '0;
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;
  bit                model_live = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .FWFT(0)) u_std (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .empty(s_empty), .full(s_full), .almost_empty(s_aempty),
    .almost_full(s_afull), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flex #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .FWFT(1)) u_fwft (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_aempty),
    .almost_full(f_afull), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model state left by the previous edge.
  task automatic checkAll();
    int n;
    logic [DWIDTH-1:0] head;
    if (!model_live) return;
    n    = exp_q.size();
    head = (n == 0) ? '0 : exp_q[0];
    checkOutput("std.count",  32'(s_count),  32'(n));
    checkOutput("fwft.count", 32'(f_count),  32'(n));
    checkOutput("std.empty",  32'(s_empty),  32'(n == 0));
    checkOutput("fwft.empty", 32'(f_empty),  32'(n == 0));
    checkOutput("std.full",   32'(s_full),   32'(n == DEPTH));
    checkOutput("fwft.full",  32'(f_full),   32'(n == DEPTH));
    checkOutput("std.aempty", 32'(s_aempty), 32'(n <= 2));
    checkOutput("fwft.aempty",32'(f_aempty), 32'(n <= 2));
    checkOutput("std.afull",  32'(s_afull),  32'(n >= DEPTH - 2));
    checkOutput("fwft.afull", 32'(f_afull),  32'(n >= DEPTH - 2));
    checkOutput("std.ovf",    32'(s_ovf),    32'(exp_ovf));
    checkOutput("fwft.ovf",   32'(f_ovf),    32'(exp_ovf));
    checkOutput("std.unf",    32'(s_unf),    32'(exp_unf));
    checkOutput("fwft.unf",   32'(f_unf),    32'(exp_unf));
    checkOutput("std.dout",   32'(s_dout),   32'(exp_dout_std));
    checkOutput("fwft.dout",  32'(f_dout),   32'(head));
  endtask

  // Drive one cycle from the falling edge, check, then advance the model across the rising edge.
  task automatic applyStimulus(input logic wr, input logic [DWIDTH-1:0] d, input logic rd,
                               input logic fl, input logic rs);
    int n;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    flush = fl;
    rstn  = rs;
    checkAll();
    @(posedge clk);
    n = exp_q.size();
    if (!rs || fl) begin
      exp_q.delete();
      exp_dout_std = '0;
      exp_ovf      = 1'b0;
      exp_unf      = 1'b0;
      model_live   = 1'b1;
    end else begin
      exp_ovf = wr && (n == DEPTH);
      exp_unf = rd && (n == 0);
      if (rd && n > 0) exp_dout_std = exp_q.pop_front();
      if (wr && n < DEPTH) exp_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic idle();                          applyStimulus(0, '0, 0, 0, 1); endtask
  task automatic push(input logic [DWIDTH-1:0] d); applyStimulus(1, d,  0, 0, 1); endtask
  task automatic pop();                           applyStimulus(0, '0, 1, 0, 1); endtask
  task automatic push_pop(input logic [DWIDTH-1:0] d); applyStimulus(1, d, 1, 0, 1); endtask

  initial begin
    rstn  = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    idle();

    $display("[TB] fill and overflow");
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    push(16'h0009);
    idle();
    idle();

    $display("[TB] drain and underflow");
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    idle();
    idle();

    $display("[TB] read and write while empty");
    push_pop(16'h0CCC);
    idle();
    pop();
    idle();

    $display("[TB] fwft visibility");
    push(16'hBEEF);
    idle();
    idle();
    pop();
    idle();

    $display("[TB] streaming at count 4");
    for (int i = 0; i < 4; i++) push(16'h0A00 + 16'(i));
    for (int i = 0; i < 20; i++) push_pop(16'h0B00 + 16'(i));
    for (int i = 0; i < 4; i++) pop();
    idle();

    $display("[TB] flush with traffic");
    for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i));
    applyStimulus(1, 16'hDEAD, 1, 1, 1);
    idle();
    push(16'h1234);
    pop();
    idle();
    idle();

    $display("[TB] reset while full");
    for (int i = 0; i < DEPTH; i++) push(16'h0600 + 16'(i));
    applyStimulus(1, 16'h5555, 1, 0, 0);
    idle();
    for (int i = 0; i < DEPTH; i++) push(16'h0700 + 16'(i));
    push_pop(16'h0777);
    idle();
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
